// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and defaults for the memory port arbiter.
//   arb_state_e      : arbiter FSM states (IDLE, GNT_IF, GNT_DM)
//   DEF_STARVE_LIMIT : default consecutive DM wins before a pending IF is forced
//   DEF_TIMEOUT_CYC  : default grant cycles without mem_ack_i before abort
//   cnt_w()          : width of a counter that must hold values 0..n
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GNT_IF = 2'd1,
        GNT_DM = 2'd2
    } arb_state_e;

    localparam int unsigned DEF_STARVE_LIMIT = 4;
    localparam int unsigned DEF_TIMEOUT_CYC  = 64;

    function automatic int unsigned cnt_w(input int unsigned n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/mem_arb_prio.sv
// mem_arb_prio: winner select for the shared memory port plus the IF
// starvation counter.
//   i_clk, i_rst_n : clock, synchronous active-low reset
//   i_idle         : arbiter is in IDLE and may issue a new grant this cycle
//   i_if_req       : IF request pending
//   i_dm_req       : DM request pending
//   o_gnt_if       : grant IF at the coming edge
//   o_gnt_dm       : grant DM at the coming edge
// DM normally wins; once DM has beaten a waiting IF STARVE_LIMIT times in a
// row the next decision with IF pending goes to IF.
module mem_arb_prio
    import mem_arb_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = DEF_STARVE_LIMIT
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_idle,
    input  logic i_if_req,
    input  logic i_dm_req,
    output logic o_gnt_if,
    output logic o_gnt_dm
);

    localparam int unsigned SW = cnt_w(STARVE_LIMIT);

    logic [SW-1:0] r_starve_cnt;
    logic          w_starved;

    assign w_starved = (r_starve_cnt >= SW'(STARVE_LIMIT));
    assign o_gnt_dm  = i_idle && i_dm_req && (!w_starved || !i_if_req);
    assign o_gnt_if  = i_idle && i_if_req && !o_gnt_dm;

    // Counts DM wins taken while IF was waiting; saturates at the limit.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_starve_cnt <= '0;
        end else if (o_gnt_if) begin
            r_starve_cnt <= '0;
        end else if (o_gnt_dm && i_if_req && !w_starved) begin
            r_starve_cnt <= r_starve_cnt + SW'(1);
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one variable-latency memory port between the
// instruction-fetch (IF) and data-memory (DM) requesters.
//   clk_i, rst_i           : clock, synchronous active-low reset
//   if_req_i/if_addr_i     : IF read request (held until if_ack_o)
//   if_rdata_o/if_ack_o    : IF read data (held between acks), completion pulse
//   dm_req_i/dm_we_i/dm_addr_i/dm_wdata_i : DM request (held until dm_ack_o)
//   dm_rdata_o/dm_ack_o    : DM read data (held between acks), completion pulse
//   mem_req_o/mem_we_o/mem_addr_o/mem_wdata_o : memory request side
//   mem_rdata_i/mem_ack_i  : memory response, one-cycle ack
//   stall_o                : some requester is still waiting this cycle
//   err_o                  : sticky, set when a grant times out
// Optional: define MEM_ARB_PERF_CNT_EN to add if_wait_cnt_o/dm_wait_cnt_o,
// saturating 32-bit counts of cycles each requester spent waiting.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W       = 32,
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned STARVE_LIMIT = DEF_STARVE_LIMIT,
    parameter int unsigned TIMEOUT_CYC  = DEF_TIMEOUT_CYC
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic [DATA_W-1:0] if_rdata_o,
    output logic              if_ack_o,
    input  logic              dm_req_i,
    input  logic              dm_we_i,
    input  logic [ADDR_W-1:0] dm_addr_i,
    input  logic [DATA_W-1:0] dm_wdata_i,
    output logic [DATA_W-1:0] dm_rdata_o,
    output logic              dm_ack_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i,
    input  logic              mem_ack_i,
    output logic              stall_o,
    output logic              err_o
`ifdef MEM_ARB_PERF_CNT_EN
    ,
    output logic [31:0]       if_wait_cnt_o,
    output logic [31:0]       dm_wait_cnt_o
`endif
);

    localparam int unsigned TW = cnt_w(TIMEOUT_CYC);

    arb_state_e        r_state;
    arb_state_e        w_next;
    logic [TW-1:0]     r_tmo_cnt;
    logic              r_err;
    logic [DATA_W-1:0] r_if_rdata;
    logic [DATA_W-1:0] r_dm_rdata;

    logic              w_idle;
    logic              w_gnt_if;
    logic              w_gnt_dm;
    logic              w_tmo;
    logic              w_done;
    logic              w_if_ack;
    logic              w_dm_ack;
    logic [DATA_W-1:0] w_resp;

    assign w_idle = (r_state == IDLE);

    mem_arb_prio #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_prio (
        .i_clk    (clk_i),
        .i_rst_n  (rst_i),
        .i_idle   (w_idle),
        .i_if_req (if_req_i),
        .i_dm_req (dm_req_i),
        .o_gnt_if (w_gnt_if),
        .o_gnt_dm (w_gnt_dm)
    );

    // Grant cycle N carries count N-1, so the abort lands on grant cycle
    // TIMEOUT_CYC.
    assign w_tmo  = (r_tmo_cnt == TW'(TIMEOUT_CYC - 1));
    assign w_done = !w_idle && (mem_ack_i || w_tmo);
    // A timed-out access delivers zero instead of whatever is on the bus.
    assign w_resp = mem_ack_i ? mem_rdata_i : '0;

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next   = r_state;
        w_if_ack = 1'b0;
        w_dm_ack = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_gnt_dm) begin
                    w_next = GNT_DM;
                end else if (w_gnt_if) begin
                    w_next = GNT_IF;
                end
            end
            GNT_IF: begin
                if (w_done) begin
                    w_if_ack = 1'b1;
                    w_next   = IDLE;
                end
            end
            GNT_DM: begin
                if (w_done) begin
                    w_dm_ack = 1'b1;
                    w_next   = IDLE;
                end
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    // Cleared while idle so every grant starts counting from zero.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_tmo_cnt <= '0;
        end else if (w_idle || w_done) begin
            r_tmo_cnt <= '0;
        end else begin
            r_tmo_cnt <= r_tmo_cnt + TW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_err <= 1'b0;
        end else if (w_done && !mem_ack_i) begin
            r_err <= 1'b1;
        end
    end

    // Read data goes straight through on the ack cycle and is held afterwards.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_if_rdata <= '0;
            r_dm_rdata <= '0;
        end else begin
            if (w_if_ack) begin
                r_if_rdata <= w_resp;
            end
            if (w_dm_ack && !dm_we_i) begin
                r_dm_rdata <= w_resp;
            end
        end
    end

    assign if_ack_o   = w_if_ack;
    assign dm_ack_o   = w_dm_ack;
    assign if_rdata_o = w_if_ack ? w_resp : r_if_rdata;
    assign dm_rdata_o = (w_dm_ack && !dm_we_i) ? w_resp : r_dm_rdata;

    assign mem_req_o   = !w_idle;
    assign mem_we_o    = (r_state == GNT_DM) && dm_we_i;
    assign mem_addr_o  = (r_state == GNT_DM) ? dm_addr_i :
                         (r_state == GNT_IF) ? if_addr_i : '0;
    assign mem_wdata_o = (r_state == GNT_DM) ? dm_wdata_i : '0;

    assign stall_o = (if_req_i && !w_if_ack) || (dm_req_i && !w_dm_ack);
    assign err_o   = r_err;

`ifdef MEM_ARB_PERF_CNT_EN
    logic [31:0] r_if_wait;
    logic [31:0] r_dm_wait;

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_if_wait <= '0;
            r_dm_wait <= '0;
        end else begin
            if (if_req_i && !w_if_ack && (r_if_wait != '1)) begin
                r_if_wait <= r_if_wait + 32'd1;
            end
            if (dm_req_i && !w_dm_ack && (r_dm_wait != '1)) begin
                r_dm_wait <= r_dm_wait + 32'd1;
            end
        end
    end

    assign if_wait_cnt_o = r_if_wait;
    assign dm_wait_cnt_o = r_dm_wait;
`endif

endmodule
